// File: rtl/wsg_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : wsg_scheduler_if
// Purpose  : Bundles the sound-register write port, the wave PROM port and
//            the mixed-sample output of the wavetable scheduler.
// Signals  : wr_en/wr_addr/wr_data   register file write strobe, index, data
//            prom_rd/prom_addr       PROM clock enable pulse and address
//            prom_data_a/prom_data_b PROM A/B data, valid the cycle after rd
//            sample_out/sample_valid signed 10-bit mix and its update pulse
// Modports : master = host/PROM side, slave = scheduler
// Revision : 1.0  initial release
// ============================================================================
interface wsg_scheduler_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       prom_rd;
  logic [7:0] prom_addr;
  logic [3:0] prom_data_a;
  logic [3:0] prom_data_b;
  logic [9:0] sample_out;
  logic       sample_valid;

  modport master (
    output wr_en, wr_addr, wr_data, prom_data_a, prom_data_b,
    input  prom_rd, prom_addr, sample_out, sample_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, prom_data_a, prom_data_b,
    output prom_rd, prom_addr, sample_out, sample_valid
  );
endinterface
`default_nettype wire

// File: rtl/wsg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : wsg_scheduler
// Purpose  : Three-voice wavetable sound scheduler. Holds 32 x 4-bit sound
//            registers, advances one 20-bit phase accumulator per voice once
//            per output sample, fetches one PROM nibble per voice and mixes
//            volume-scaled, offset-removed samples into a signed 10-bit sum.
//            CLK_HZ/SAMPLE_HZ must be at least 16 so a frame (11 cycles)
//            always completes before the next one starts.
// Ports    : clk    rising-edge clock
//            reset  asynchronous, active-high reset
//            bus    wsg_scheduler_if.slave (register writes, PROM, samples)
// Revision : 1.0  initial release
// ============================================================================
module wsg_scheduler #(
  parameter int CLK_HZ    = 47828000,
  parameter int SAMPLE_HZ = 24000
) (
  input  wire logic         clk,
  input  wire logic         reset,
  wsg_scheduler_if.slave    bus
);

  localparam int c_DIV    = CLK_HZ / SAMPLE_HZ;
  localparam int c_TICK_W = $clog2(c_DIV);
  localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(c_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_ACC  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // Sound register file
  logic [31:0][3:0]    r_regs;

  // Scheduler state
  state_t              r_state;
  logic [c_TICK_W-1:0] r_tick;
  logic                r_frame;
  logic [1:0]          r_voice;
  logic signed [9:0]   r_acc;
  logic [2:0][19:0]    r_phase;
  logic                r_prom_rd;
  logic [7:0]          r_prom_addr;
  logic [9:0]          r_sample;
  logic                r_valid;

  // Per-voice decoded register fields
  logic [2:0][3:0]     w_wave;
  logic [2:0][3:0]     w_vol;
  logic [2:0][3:0]     w_low;
  logic [2:0][19:0]    w_freq;

  logic                w_sel_b;
  logic [3:0]          w_s;
  logic signed [4:0]   w_diff;
  logic signed [9:0]   w_term;
  logic [1:0]          w_next_voice;
  logic                w_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs <= '0;
    end else if (bus.wr_en) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Voice v uses registers at offset 5*v; only voice 0 has a low freq nibble.
  for (genvar gv = 0; gv < 3; gv++) begin : g_voice
    localparam int c_OFF = 5 * gv;
    if (gv == 0) begin : g_low
      assign w_low[gv] = r_regs[16];
    end else begin : g_no_low
      assign w_low[gv] = 4'h0;
    end
    assign w_wave[gv] = r_regs[5 + c_OFF];
    assign w_vol[gv]  = r_regs[21 + c_OFF];
    assign w_freq[gv] = {r_regs[20 + c_OFF], r_regs[19 + c_OFF],
                         r_regs[18 + c_OFF], r_regs[17 + c_OFF], w_low[gv]};
  end

  // Registers without a function here stay writable but are never decoded.
  assign w_unused = ^{r_regs[14:11], r_regs[9:6], r_regs[4:0]};

  // Remove the PROM's mid-scale offset of 7 and scale by volume. The product
  // always fits in 8 bits signed (-105..+120); it is formed directly at the
  // accumulator width so it is already sign-extended.
  assign w_sel_b      = w_wave[r_voice][3];
  assign w_s          = w_sel_b ? bus.prom_data_b : bus.prom_data_a;
  assign w_diff       = $signed({1'b0, w_s}) - 5'sd7;
  assign w_term       = $signed({6'b0, w_vol[r_voice]}) *
                        $signed({{5{w_diff[4]}}, w_diff});
  assign w_next_voice = r_voice + 2'd1;

  // prom_rd/prom_addr and sample_valid/sample_out are registered, so they are
  // loaded on the transition into ADDR/OUT respectively.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_frame     <= 1'b0;
      r_voice     <= 2'd0;
      r_acc       <= '0;
      r_phase     <= '0;
      r_prom_rd   <= 1'b0;
      r_prom_addr <= 8'h00;
      r_sample    <= 10'h000;
      r_valid     <= 1'b0;
    end else begin
      // r_frame marks the cycle in which the tick counter has just wrapped.
      r_tick    <= (r_tick == c_TICK_MAX) ? '0 : r_tick + c_TICK_W'(1);
      r_frame   <= (r_tick == c_TICK_MAX);
      r_prom_rd <= 1'b0;
      r_valid   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_voice <= 2'd0;
          r_acc   <= '0;
          if (r_frame) begin
            r_state     <= S_ADDR;
            r_prom_rd   <= 1'b1;
            r_prom_addr <= {w_wave[0][2:0], r_phase[0][17:13]};
          end
        end

        S_ADDR: r_state <= S_WAIT;

        S_WAIT: r_state <= S_ACC;

        S_ACC: begin
          r_acc            <= r_acc + w_term;
          r_phase[r_voice] <= r_phase[r_voice] + w_freq[r_voice];
          if (r_voice != 2'd2) begin
            // The next voice's phase is untouched this cycle, so its
            // pre-update value is what the address uses.
            r_voice     <= w_next_voice;
            r_state     <= S_ADDR;
            r_prom_rd   <= 1'b1;
            r_prom_addr <= {w_wave[w_next_voice][2:0],
                            r_phase[w_next_voice][17:13]};
          end else begin
            r_state  <= S_OUT;
            r_sample <= r_acc + w_term;
            r_valid  <= 1'b1;
          end
        end

        S_OUT: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.prom_rd      = r_prom_rd;
  assign bus.prom_addr    = r_prom_addr;
  assign bus.sample_out   = r_sample;
  assign bus.sample_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_wsg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_wsg_scheduler
// Purpose  : Self-checking bench for wsg_scheduler. A frame-level model
//            predicts PROM addresses and mixed samples from the register
//            contents; a compare process checks every cycle, and directed
//            scenarios pin literal values.
// Revision : 1.0  initial release
// ============================================================================
module tb_wsg_scheduler;

  localparam int DIV = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   prom_mode = 0;
  int   cyc;
  logic [3:0] mregs [32];

  wsg_scheduler_if bus ();

  wsg_scheduler #(.CLK_HZ(32), .SAMPLE_HZ(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // mode 0: both PROMs return F; mode 1: return addr[3:0]; mode 2: A=F, B=0
  function automatic logic [3:0] prom_fn(input int mode, input logic [7:0] a,
                                         input bit sel_b);
    case (mode)
      1:       return a[3:0];
      2:       return sel_b ? 4'h0 : 4'hF;
      default: return 4'hF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.prom_rd) begin
      bus.prom_data_a <= prom_fn(prom_mode, bus.prom_addr, 1'b0);
      bus.prom_data_b <= prom_fn(prom_mode, bus.prom_addr, 1'b1);
    end
  end

  // cyc = cycles since reset release; the model register file follows writes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0;
      for (int i = 0; i < 32; i++) mregs[i] <= 4'h0;
    end else begin
      cyc <= cyc + 1;
      if (bus.wr_en) mregs[bus.wr_addr] <= bus.wr_data;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Frame model and per-cycle compare
  initial begin : compare
    int p, k, sum, s, o, vol, wave, freq;
    logic [7:0]  a;
    logic [19:0] mphase [3];
    logic [7:0]  f_addr [3];
    logic [9:0]  f_sum;
    logic [7:0]  exp_addr;
    logic [9:0]  exp_sample;
    bit want_rd, want_valid;
    for (int v = 0; v < 3; v++) begin mphase[v] = '0; f_addr[v] = '0; end
    f_sum = '0; exp_addr = '0; exp_sample = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int v = 0; v < 3; v++) mphase[v] = '0;
        exp_addr = '0;
        exp_sample = '0;
        chk("rst_prom_rd", int'(bus.prom_rd), 0);
        chk("rst_prom_addr", int'(bus.prom_addr), 0);
        chk("rst_sample_valid", int'(bus.sample_valid), 0);
        chk("rst_sample_out", int'(bus.sample_out), 0);
      end else begin
        p = cyc % DIV;
        k = cyc / DIV;
        if (k >= 1 && p == 0) begin
          sum = 0;
          for (int v = 0; v < 3; v++) begin
            o    = 5 * v;
            wave = int'(mregs[5 + o]);
            vol  = int'(mregs[21 + o]);
            freq = int'(mregs[17 + o]) * 16 + int'(mregs[18 + o]) * 256 +
                   int'(mregs[19 + o]) * 4096 + int'(mregs[20 + o]) * 65536 +
                   ((v == 0) ? int'(mregs[16]) : 0);
            a    = 8'((wave % 8) * 32 + int'(mphase[v][17:13]));
            s    = int'(prom_fn(prom_mode, a, wave >= 8));
            sum  = sum + vol * (s - 7);
            f_addr[v] = a;
            mphase[v] = 20'((int'(mphase[v]) + freq) % (1 << 20));
          end
          f_sum = 10'(sum);
        end
        want_rd    = (k >= 1) && (p == 1 || p == 4 || p == 7);
        want_valid = (k >= 1) && (p == 10);
        if (want_rd)    exp_addr   = f_addr[(p - 1) / 3];
        if (want_valid) exp_sample = f_sum;
        chk("prom_rd", int'(bus.prom_rd), int'(want_rd));
        chk("prom_addr", int'(bus.prom_addr), int'(exp_addr));
        chk("sample_valid", int'(bus.sample_valid), int'(want_valid));
        chk("sample_out", int'(bus.sample_out), int'(exp_sample));
      end
    end
  end

  task automatic to_cycle(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : main
    int nv;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Bench 1: full volume, PROM = F -> 3 * 15 * 8 = 360 every frame
    do_reset();
    prom_mode = 0;
    wr(5'h15, 4'hF); wr(5'h1A, 4'hF); wr(5'h1F, 4'hF); wr(5'h11, 4'h3);
    to_cycle(DIV);
    nv = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if (bus.sample_valid) nv++;
      if (cyc == DIV + 10) begin
        chk("b1_valid", int'(bus.sample_valid), 1);
        chk("b1_sample", int'(bus.sample_out), 'h168);
      end
      @(negedge clk);
    end
    chk("b1_valid_count", nv, 3);

    // Bench 2: volumes 0, voice-0 freq 0x04000 -> phase[17:13] steps by 2
    do_reset();
    wr(5'h13, 4'h4);
    for (int f = 1; f <= 3; f++) begin
      to_cycle(f * DIV + 1);
      chk("b2_addr", int'(bus.prom_addr), 2 * (f - 1));
      to_cycle(f * DIV + 10);
      chk("b2_sample", int'(bus.sample_out), 0);
    end

    // Bench 3: freq 0x02000 -> address low bits 0..31 then wrap to 0
    do_reset();
    prom_mode = 1;
    wr(5'h13, 4'h2); wr(5'h15, 4'h5);
    for (int f = 1; f <= 33; f++) begin
      to_cycle(f * DIV + 1);
      chk("b3_addr_lo", int'(bus.prom_addr[4:0]), (f - 1) % 32);
    end

    // Bench 4: voice 1 wave 9 reads PROM B = 0 at volume 15 -> -105
    do_reset();
    prom_mode = 2;
    wr(5'h0A, 4'h9); wr(5'h1A, 4'hF);
    to_cycle(DIV + 4);
    chk("b4_addr", int'(bus.prom_addr), 'h20);
    to_cycle(DIV + 10);
    chk("b4_sample", int'(bus.sample_out), 'h397);

    // Bench 5: reset during voice-1 WAIT of frame 2
    do_reset();
    prom_mode = 0;
    wr(5'h15, 4'hF); wr(5'h1A, 4'hF); wr(5'h1F, 4'hF); wr(5'h19, 4'h1);
    to_cycle(2 * DIV + 4);
    chk("b5_pre_rd", int'(bus.prom_rd), 1);
    chk("b5_pre_addr", int'(bus.prom_addr), 'h08);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("b5_rst_sample", int'(bus.sample_out), 0);
    chk("b5_rst_valid", int'(bus.sample_valid), 0);
    chk("b5_rst_rd", int'(bus.prom_rd), 0);
    chk("b5_rst_addr", int'(bus.prom_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nv = 0;
    while (!bus.sample_valid && nv < 200) begin
      @(negedge clk);
      nv++;
    end
    chk("b5_first_valid_delay", nv, DIV + 10);
    chk("b5_first_sample", int'(bus.sample_out), 0);

    // Bench 6: volume write in voice-0 ACC applies from the next frame
    do_reset();
    prom_mode = 0;
    wr(5'h15, 4'h5);
    to_cycle(DIV + 3);
    wr(5'h15, 4'hF);
    to_cycle(DIV + 10);
    chk("b6_old_vol", int'(bus.sample_out), 'h028);
    to_cycle(2 * DIV + 10);
    chk("b6_new_vol", int'(bus.sample_out), 'h078);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wsg_scheduler.md
WSG_SCHEDULER -- requirements
Module: wsg_scheduler

Interface
- REQ-001: Parameter CLK_HZ, default 47828000, is the clk frequency in Hz.
- REQ-002: Parameter SAMPLE_HZ, default 24000, is the output sample rate in Hz; DIV = CLK_HZ/SAMPLE_HZ (integer division) SHALL be >= 16.
- REQ-003: clk  input  1  single clock; all logic on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: wr_en  input  1  write strobe for the sound register file, one cycle per write.
- REQ-006: wr_addr  input  5  sound register index 0x00..0x1F.
- REQ-007: wr_data  input  4  sound register data.
- REQ-008: prom_rd  output  1  wave PROM clock enable, one-cycle pulse.
- REQ-009: prom_addr  output  8  wave PROM address {wave[2:0], phase[17:13]}.
- REQ-010: prom_data_a  input  4  PROM A output, valid the cycle after prom_rd.
- REQ-011: prom_data_b  input  4  PROM B output, valid the cycle after prom_rd.
- REQ-012: sample_out  output  10  signed two's-complement mixed sample of 3 voices.
- REQ-013: sample_valid  output  1  one-cycle pulse when sample_out updates.

Function
- REQ-014: The block SHALL hold 32 x 4-bit sound registers; regs[wr_addr] <= wr_data on each clk with wr_en=1.
- REQ-015: For voice v (0..2), off = 5*v: wave = regs[0x05+off], volume = regs[0x15+off], freq = {regs[0x14+off], regs[0x13+off], regs[0x12+off], regs[0x11+off], low}, where low = regs[0x10] for v=0 and 4'h0 otherwise.
- REQ-016: The block SHALL hold three 20-bit phase accumulators, one per voice, wrapping modulo 2^20.
- REQ-017: A tick counter SHALL count 0..DIV-1 and wrap; a frame starts in the cycle the counter wraps to 0.
- REQ-018: FSM states: IDLE, ADDR, WAIT, ACC, OUT.
- REQ-019: IDLE: voice index <= 0, acc_sum <= 0; on frame start -> ADDR.
- REQ-020: ADDR: prom_rd=1; prom_addr from the current voice's wave[2:0] and phase[17:13] (pre-update value); -> WAIT.
- REQ-021: WAIT: prom_rd=0; -> ACC.
- REQ-022: ACC: s = wave[3] ? prom_data_b : prom_data_a; term = volume * (s - 7) as 8-bit signed, range -105..+120; acc_sum <= acc_sum + sign-extended term (10-bit signed); phase[v] <= phase[v] + freq; if v<2: v <= v+1, -> ADDR; else -> OUT.
- REQ-023: OUT: sample_out <= acc_sum; sample_valid=1 for this cycle only; -> IDLE.
- REQ-024: Frame latency SHALL be fixed: sample_valid rises 10 cycles after the frame-start cycle (3 cycles per voice, then OUT).
- REQ-025: Register and phase values used in ACC are the values current in that cycle; a write landing in the same cycle takes effect from the next cycle.
- REQ-026: Volume 0 contributes 0 to acc_sum, but the phase for that voice SHALL still advance.
- REQ-027: Maximum |acc_sum| is 360, so a 10-bit signed value SHALL NOT overflow.
- REQ-028: Because DIV >= 16 exceeds frame length 11, a frame start SHALL never occur outside IDLE; no overrun handling is required.
- REQ-029: prom_addr SHALL hold its last value outside ADDR; prom_rd SHALL be 0 outside ADDR.

Reset
- REQ-030: Asserting reset, at any time including mid-frame, SHALL immediately force: FSM=IDLE, tick counter=0, voice index=0, acc_sum=0, all 32 registers=0, all phases=0, sample_out=0, sample_valid=0, prom_rd=0, prom_addr=0.
- REQ-031: After reset deasserts, the first frame start SHALL occur DIV cycles later.

Verification
- REQ-032: Bench 1: PROM model returns 4'hF; all three volumes=15, waves=0 -> sample_out=0x168 (360) every frame; sample_valid pulses exactly once per DIV cycles.
- REQ-033: Bench 2: all volumes=0, any freq -> sample_out=0; voice-0 phase still advances by freq each frame.
- REQ-034: Bench 3: voice 0 freq=0x02000, wave=0; PROM model returns address[4:0] -> prom_addr low bits read 0,1,2,...,31,0 over consecutive frames (wrap).
- REQ-035: Bench 4: voice 1 wave=4'h9 (PROM B, wave 1), PROM B returns 0, volume=15 -> term=-105; sample_out=10'h397.
- REQ-036: Bench 5: assert reset in WAIT of voice 1 -> all outputs 0 in the same cycle; first sample_valid occurs DIV+10 cycles after deassert, with value 0.
- REQ-037: Bench 6: write volume 0x15=15 in the same cycle as voice-0 ACC -> that frame uses the old volume; the next frame uses 15.
